// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Brief    : Handshaked sequential ALU; single-cycle add/sub/mul/pass and an
//            N-cycle restoring divider for div/mod, with registered flags.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [2:0]   sel,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [N-1:0] C,
  output logic         Z,
  output logic         CO,
  output logic         DZ
);

  localparam int CW = $clog2(N + 1);

  localparam logic [2:0]    c_add  = 3'b000;
  localparam logic [2:0]    c_sub  = 3'b001;
  localparam logic [2:0]    c_mul  = 3'b010;
  localparam logic [2:0]    c_div  = 3'b011;
  localparam logic [2:0]    c_mod  = 3'b100;
  localparam logic [CW-1:0] c_last = CW'(N - 1);
  localparam logic [CW-1:0] c_one  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        r_state;
  logic [N-1:0]  r_rem;
  logic [N-1:0]  r_quo;
  logic [N-1:0]  r_div;
  logic          r_mod;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_c;
  logic          r_z;
  logic          r_co;
  logic          r_dz;
  logic          r_mval;

  logic [N:0]     w_sum;
  logic [N:0]     w_diff;
  logic [2*N-1:0] w_prod;
  logic [N-1:0]   w_c;
  logic           w_co;
  logic           w_dz;
  logic           w_iter;

  logic [N:0]     w_trial;
  logic [N:0]     w_trial_sub;
  logic           w_ge;
  logic [N-1:0]   w_rem_nx;
  logic [N-1:0]   w_quo_nx;
  logic [N-1:0]   w_div_res;

  assign s_ready = (r_state == IDLE);
  assign m_valid = r_mval;
  assign C       = r_c;
  assign Z       = r_z;
  assign CO      = r_co;
  assign DZ      = r_dz;

  assign w_sum  = {1'b0, A} + {1'b0, B};
  assign w_diff = {1'b0, A} - {1'b0, B};
  assign w_prod = {{N{1'b0}}, A} * {{N{1'b0}}, B};
  assign w_iter = ((sel == c_div) || (sel == c_mod)) && (B != '0);

  always_comb begin
    w_c  = A;
    w_co = 1'b0;
    w_dz = 1'b0;
    case (sel)
      c_add: begin
        w_c  = w_sum[N-1:0];
        w_co = w_sum[N];
      end
      c_sub: begin
        w_c  = w_diff[N-1:0];
        w_co = w_diff[N];
      end
      c_mul: begin
        w_c  = w_prod[N-1:0];
        w_co = |w_prod[2*N-1:N];
      end
      c_div: begin
        if (B == '0) begin
          w_c  = '1;
          w_dz = 1'b1;
        end
      end
      c_mod: begin
        if (B == '0) begin
          w_dz = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // One restoring step: shift the next dividend bit into the partial remainder.
  assign w_trial     = {r_rem, r_quo[N-1]};
  assign w_trial_sub = w_trial - {1'b0, r_div};
  assign w_ge        = (w_trial >= {1'b0, r_div});
  assign w_rem_nx    = w_ge ? w_trial_sub[N-1:0] : w_trial[N-1:0];
  assign w_quo_nx    = {r_quo[N-2:0], w_ge};
  assign w_div_res   = r_mod ? w_rem_nx : w_quo_nx;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_mod   <= 1'b0;
      r_cnt   <= '0;
      r_c     <= '0;
      r_z     <= 1'b0;
      r_co    <= 1'b0;
      r_dz    <= 1'b0;
      r_mval  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (s_valid) begin
            if (w_iter) begin
              r_rem   <= '0;
              r_quo   <= A;
              r_div   <= B;
              r_mod   <= (sel == c_mod);
              r_cnt   <= '0;
              r_state <= BUSY;
            end else begin
              r_c     <= w_c;
              r_z     <= (w_c == '0);
              r_co    <= w_co;
              r_dz    <= w_dz;
              r_mval  <= 1'b1;
              r_state <= HOLD;
            end
          end
        end
        BUSY: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt + c_one;
          // The final step publishes its result directly, so BUSY lasts N cycles.
          if (r_cnt == c_last) begin
            r_c     <= w_div_res;
            r_z     <= (w_div_res == '0);
            r_co    <= 1'b0;
            r_dz    <= 1'b0;
            r_mval  <= 1'b1;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (m_ready) begin
            r_mval  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Brief    : Directed plus randomized bench for alu_seq against an arithmetic
//            reference model. Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

  localparam int N = 8;
  localparam int M = 1 << N;

  logic         clk;
  logic         rstn;
  logic         s_valid;
  logic         s_ready;
  logic [2:0]   sel;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         m_valid;
  logic         m_ready;
  logic [N-1:0] c;
  logic         z;
  logic         co;
  logic         dz;

  int n_vec;
  int n_err;

  alu_seq #(.N(N)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .sel     (sel),
    .A       (a),
    .B       (b),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .C       (c),
    .Z       (z),
    .CO      (co),
    .DZ      (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: {dz, co, c} from the opcode rules using plain integer arithmetic.
  function automatic void model(input int op, input int x, input int y,
                                output int rc, output int rco, output int rdz,
                                output int lat);
    int full;
    rco = 0;
    rdz = 0;
    lat = 1;
    case (op)
      0: begin full = x + y; rc = full % M; rco = (full >= M) ? 1 : 0; end
      1: begin rc = (x - y + M) % M; rco = (x < y) ? 1 : 0; end
      2: begin full = x * y; rc = full % M; rco = (full >= M) ? 1 : 0; end
      3: begin
        if (y == 0) begin rc = M - 1; rdz = 1; end
        else begin rc = x / y; lat = N + 1; end
      end
      4: begin
        if (y == 0) begin rc = x; rdz = 1; end
        else begin rc = x % y; lat = N + 1; end
      end
      default: rc = x;
    endcase
  endfunction

  // Issue one request from a negedge, check latency, result, hold and release.
  task automatic do_op(input int op, input int x, input int y, input int hold);
    int ec, eco, edz, elat, lat;
    model(op, x, y, ec, eco, edz, elat);
    chk("s_ready_idle", 32'(s_ready), 32'd1);
    sel     = 3'(op);
    a       = N'(x);
    b       = N'(y);
    s_valid = 1'b1;
    m_ready = (hold == 0);
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        s_valid = 1'b0;
        sel     = 3'($urandom);
        a       = N'($urandom);
        b       = N'($urandom);
      end
      if (!m_valid) chk("s_ready_busy", 32'(s_ready), 32'd0);
    end while (!m_valid && lat < 40);
    chk("latency", lat, elat);
    chk("C", 32'(c), ec);
    chk("Z", 32'(z), (ec == 0) ? 1 : 0);
    chk("CO", 32'(co), eco);
    chk("DZ", 32'(dz), edz);
    for (int h = 0; h < hold; h++) begin
      s_valid = 1'($urandom);
      sel     = 3'($urandom);
      a       = N'($urandom);
      b       = N'($urandom);
      @(negedge clk);
      chk("hold_m_valid", 32'(m_valid), 32'd1);
      chk("hold_s_ready", 32'(s_ready), 32'd0);
      chk("hold_C", 32'(c), ec);
      chk("hold_flags", {29'd0, z, co, dz}, {29'd0, 1'(ec == 0), 1'(eco), 1'(edz)});
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    chk("release_m_valid", 32'(m_valid), 32'd0);
    chk("release_s_ready", 32'(s_ready), 32'd1);
    m_ready = 1'b0;
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rstn    = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    sel     = '0;
    a       = '0;
    b       = '0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {27'd0, m_valid, c, z, co, dz}, 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    rstn = 1'b1;
    @(negedge clk);

    do_op(0, 200, 100, 0);
    do_op(1, 5, 5, 1);
    do_op(1, 3, 5, 0);
    do_op(2, 20, 20, 2);
    do_op(3, 200, 7, 0);
    do_op(4, 200, 7, 1);
    do_op(3, 13, 0, 0);
    do_op(4, 13, 0, 0);
    do_op(0, 1, 1, 0);
    do_op(2, 15, 17, 5);
    do_op(3, 255, 1, 5);
    do_op(5, 77, 3, 0);
    do_op(7, 0, 9, 0);

    // Reset four cycles into a division must abort it without a result.
    sel     = 3'd3;
    a       = 8'd255;
    b       = 8'd1;
    s_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("abort_outputs", {27'd0, m_valid, c, z, co, dz}, 32'd0);
    chk("abort_s_ready", 32'(s_ready), 32'd1);
    repeat (2) @(negedge clk);
    chk("abort_held", 32'(m_valid), 32'd0);
    rstn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_no_result", 32'(m_valid), 32'd0);
    end
    do_op(3, 255, 1, 0);

    for (int i = 0; i < 40; i++) begin
      int op, x, y;
      op = int'($urandom_range(0, 7));
      x  = int'($urandom_range(0, M - 1));
      y  = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, M - 1));
      do_op(op, x, y, int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: N, default 8, operand/result width in bits (N >= 2).
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rstn  in  1  reset; asynchronous assertion, active-low.
REQ-004 Port: s_valid  in  1  request valid.
REQ-005 Port: s_ready  out  1  request accepted when s_valid && s_ready at a rising edge.
REQ-006 Port: sel  in  3  opcode: 000 add, 001 sub, 010 mul, 011 div, 100 mod, 101-111 pass A.
REQ-007 Port: A, B  in  N each  unsigned operands.
REQ-008 Port: m_valid  out  1  result valid.
REQ-009 Port: m_ready  in  1  result consumed when m_valid && m_ready at a rising edge.
REQ-010 Port: C  out  N  registered result.
REQ-011 Port: Z  out  1  registered, 1 iff C == 0.
REQ-012 Port: CO  out  1  registered carry/borrow/overflow flag.
REQ-013 Port: DZ  out  1  registered divide-by-zero flag.

Function
REQ-014 FSM states IDLE, BUSY, HOLD; s_ready = 1 only in IDLE (combinational decode of state only).
REQ-015 sel, A and B are captured on acceptance; changes to them after acceptance have no effect on the in-flight operation.
REQ-016 Add/sub/mul/pass and div/mod with B == 0: IDLE -> HOLD on acceptance; m_valid rises the cycle after acceptance (latency 1).
REQ-017 Div/mod with B != 0: IDLE -> BUSY; restoring shift-subtract, one quotient bit per cycle, exactly N cycles in BUSY, then HOLD; m_valid rises N+1 cycles after acceptance.
REQ-018 HOLD: m_valid = 1; C, Z, CO, DZ held stable; on m_ready -> IDLE, m_valid = 0 next cycle.
REQ-019 Back-to-back throughput: minimum 2 cycles per single-cycle op (HOLD -> IDLE -> accept).
REQ-020 Add: C = (A+B) mod 2^N, CO = carry out of bit N-1.
REQ-021 Sub: C = (A-B) mod 2^N, CO = 1 iff A < B (borrow).
REQ-022 Mul: C = low N bits of full 2N-bit product, CO = 1 iff upper N bits nonzero.
REQ-023 Div: C = floor(A/B); mod: C = A mod B; CO = 0 for both.
REQ-024 Div by zero: C = all ones (div) or A (mod), DZ = 1; DZ = 0 for all other results.
REQ-025 Pass (101-111): C = A, CO = 0.
REQ-026 Z, CO, DZ update in the same cycle as C and m_valid; never change while m_valid = 1.
REQ-027 Iteration counter sized clog2(N+1) bits; no wrap-around beyond N iterations.

Reset
REQ-028 rstn low: state = IDLE, m_valid = 0, C = 0, Z = 0, CO = 0, DZ = 0, counter and divider registers cleared, immediately (asynchronously).
REQ-029 After rstn deasserts, s_ready = 1 and the first rising edge with s_valid accepts a request.
REQ-030 Reset during BUSY or HOLD aborts the operation; the aborted result is never presented.

Verification (N = 8)
REQ-031 add A=200 B=100, m_ready=1 -> next cycle m_valid=1, C=44, CO=1, Z=0, DZ=0.
REQ-032 sub 5-5 -> C=0, Z=1, CO=0; sub 3-5 -> C=254, CO=1; mul 20*20 -> C=144, CO=1.
REQ-033 div 200/7 -> m_valid exactly 9 cycles after acceptance, C=28; mod 200%7 -> C=4; s_ready=0 throughout.
REQ-034 div 13/0 -> latency 1, C=255, DZ=1; mod 13%0 -> C=13, DZ=1; following add 1+1 -> C=2, DZ=0.
REQ-035 m_ready=0 for 5 cycles after result -> m_valid, C, flags stable, s_ready=0, s_valid pulses ignored; m_ready=1 -> m_valid=0 next cycle.
REQ-036 rstn low 4 cycles into div 255/1 -> all outputs 0, state IDLE, no m_valid; subsequent div 255/1 -> C=255.
